// File: rtl/t03_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : t03_alu_arbiter
//  Brief    : Two-port arbiter/sequencer sharing one combinational ALU.
//             Grants one requester, holds its operands on the ALU for one
//             cycle, registers result and flags, and returns them through a
//             valid/ready response handshake.
//  Revision : 1.0  initial release
// ============================================================================
module t03_alu_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    // request port 0
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_ctrl,
    input  logic [2:0]  req0_sel,
    input  logic [31:0] req0_pc,
    input  logic [31:0] req0_imm,
    input  logic [31:0] req0_rd1,
    input  logic [31:0] req0_rd2,
    // request port 1
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_ctrl,
    input  logic [2:0]  req1_sel,
    input  logic [31:0] req1_pc,
    input  logic [31:0] req1_imm,
    input  logic [31:0] req1_rd1,
    input  logic [31:0] req1_rd2,
    // response ports
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic [2:0]  rsp0_flags,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [2:0]  rsp1_flags,
    // ALU side
    output logic [3:0]  alu_control,
    output logic [31:0] alu_pc,
    output logic [31:0] alu_immediate,
    output logic [31:0] alu_rd1,
    output logic [31:0] alu_rd2,
    output logic        alu_alusrc,
    output logic        alu_auipc,
    output logic        alu_lui,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_last_grant;
    logic        r_gnt;
    logic [3:0]  r_ctrl;
    logic [2:0]  r_sel;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_result;
    logic [2:0]  r_flags;

    logic        w_grant_port;
    logic        w_accept;
    logic        w_rsp_ready_sel;

    // Winner selection: a lone requester always wins; on a tie either port 0
    // (fixed priority) or the port that was not granted last time wins.
    always_comb begin
        w_grant_port = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO != 0) begin
                w_grant_port = 1'b0;
            end else begin
                w_grant_port = ~r_last_grant;
            end
        end else if (req1_valid) begin
            w_grant_port = 1'b1;
        end
    end

    // A grant happens only from IDLE, never during flush or reset.
    assign w_accept        = (r_state == S_IDLE) && (req0_valid || req1_valid) && !flush && !rst;
    assign req0_ready      = w_accept && !w_grant_port;
    assign req1_ready      = w_accept &&  w_grant_port;
    assign w_rsp_ready_sel = r_gnt ? rsp1_ready : rsp0_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush always wins over a response handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = flush ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                if (flush || w_rsp_ready_sel) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture on grant and result capture at the end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_ctrl       <= 4'd0;
            r_sel        <= 3'd0;
            r_pc         <= 32'd0;
            r_imm        <= 32'd0;
            r_rd1        <= 32'd0;
            r_rd2        <= 32'd0;
            r_result     <= 32'd0;
            r_flags      <= 3'd0;
        end else begin
            if (w_accept) begin
                r_gnt        <= w_grant_port;
                r_last_grant <= w_grant_port;
                r_ctrl       <= w_grant_port ? req1_ctrl : req0_ctrl;
                r_sel        <= w_grant_port ? req1_sel  : req0_sel;
                r_pc         <= w_grant_port ? req1_pc   : req0_pc;
                r_imm        <= w_grant_port ? req1_imm  : req0_imm;
                r_rd1        <= w_grant_port ? req1_rd1  : req0_rd1;
                r_rd2        <= w_grant_port ? req1_rd2  : req0_rd2;
            end
            if ((r_state == S_EXEC) && !flush) begin
                r_result <= alu_result;
                r_flags  <= {alu_zero, alu_negative, alu_overflow};
            end
        end
    end

    // ALU inputs carry the granted operands while busy, zeros (ADD 0+0) when idle.
    always_comb begin
        alu_control   = 4'd0;
        alu_pc        = 32'd0;
        alu_immediate = 32'd0;
        alu_rd1       = 32'd0;
        alu_rd2       = 32'd0;
        alu_lui       = 1'b0;
        alu_auipc     = 1'b0;
        alu_alusrc    = 1'b0;
        if (r_state != S_IDLE) begin
            alu_control   = r_ctrl;
            alu_pc        = r_pc;
            alu_immediate = r_imm;
            alu_rd1       = r_rd1;
            alu_rd2       = r_rd2;
            alu_lui       = r_sel[2];
            alu_auipc     = r_sel[1];
            alu_alusrc    = r_sel[0];
        end
    end

    // Response is steered to the granted port only; data registers are shared.
    assign rsp0_valid  = (r_state == S_RESP) && !r_gnt;
    assign rsp1_valid  = (r_state == S_RESP) &&  r_gnt;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_flags  = r_flags;
    assign rsp1_flags  = r_flags;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_t03_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t03_alu_arbiter
//  Brief    : Self-checking bench for t03_alu_arbiter with a behavioural ALU.
//             A round-robin and a fixed-priority instance share all inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_t03_alu_arbiter;

    typedef struct {
        logic        port;
        logic [3:0]  ctrl;
        logic [2:0]  sel;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic [2:0]  req0_sel = '0, req1_sel = '0;
    logic [31:0] req0_pc = '0, req0_imm = '0, req0_rd1 = '0, req0_rd2 = '0;
    logic [31:0] req1_pc = '0, req1_imm = '0, req1_rd1 = '0, req1_rd2 = '0;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;

    // round-robin instance outputs
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp0_result, rsp1_result;
    logic [2:0]  rsp0_flags, rsp1_flags;
    logic [3:0]  alu_control;
    logic [31:0] alu_pc, alu_immediate, alu_rd1, alu_rd2, alu_result;
    logic        alu_alusrc, alu_auipc, alu_lui, alu_zero, alu_negative, alu_overflow;

    // fixed-priority instance outputs
    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
    logic [31:0] fp_rsp0_result, fp_rsp1_result;
    logic [2:0]  fp_rsp0_flags, fp_rsp1_flags;
    logic [3:0]  fp_alu_control;
    logic [31:0] fp_alu_pc, fp_alu_immediate, fp_alu_rd1, fp_alu_rd2, fp_alu_result;
    logic        fp_alu_alusrc, fp_alu_auipc, fp_alu_lui, fp_alu_zero, fp_alu_negative, fp_alu_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[9];

    always #5 clk = ~clk;

    // Behavioural ALU: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
    function automatic logic [34:0] alu_model(input logic [3:0] c, input logic [2:0] s,
                                              input logic [31:0] pc, input logic [31:0] imm,
                                              input logic [31:0] a1, input logic [31:0] a2);
        logic [31:0] a, b, r;
        logic ov;
        a  = s[2] ? 32'd0 : (s[1] ? pc : a1);
        b  = s[0] ? imm : a2;
        ov = 1'b0;
        case (c)
            4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r[31], ov, r};
    endfunction

    assign {alu_zero, alu_negative, alu_overflow, alu_result} =
        alu_model(alu_control, {alu_lui, alu_auipc, alu_alusrc}, alu_pc, alu_immediate, alu_rd1, alu_rd2);
    assign {fp_alu_zero, fp_alu_negative, fp_alu_overflow, fp_alu_result} =
        alu_model(fp_alu_control, {fp_alu_lui, fp_alu_auipc, fp_alu_alusrc}, fp_alu_pc,
                  fp_alu_immediate, fp_alu_rd1, fp_alu_rd2);

    t03_alu_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl), .req0_sel(req0_sel),
        .req0_pc(req0_pc), .req0_imm(req0_imm), .req0_rd1(req0_rd1), .req0_rd2(req0_rd2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl), .req1_sel(req1_sel),
        .req1_pc(req1_pc), .req1_imm(req1_imm), .req1_rd1(req1_rd1), .req1_rd2(req1_rd2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_control(alu_control), .alu_pc(alu_pc), .alu_immediate(alu_immediate),
        .alu_rd1(alu_rd1), .alu_rd2(alu_rd2), .alu_alusrc(alu_alusrc), .alu_auipc(alu_auipc),
        .alu_lui(alu_lui), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow), .busy(busy)
    );

    t03_alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_ctrl(req0_ctrl), .req0_sel(req0_sel),
        .req0_pc(req0_pc), .req0_imm(req0_imm), .req0_rd1(req0_rd1), .req0_rd2(req0_rd2),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_ctrl(req1_ctrl), .req1_sel(req1_sel),
        .req1_pc(req1_pc), .req1_imm(req1_imm), .req1_rd1(req1_rd1), .req1_rd2(req1_rd2),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(fp_rsp0_result), .rsp0_flags(fp_rsp0_flags),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(fp_rsp1_result), .rsp1_flags(fp_rsp1_flags),
        .alu_control(fp_alu_control), .alu_pc(fp_alu_pc), .alu_immediate(fp_alu_immediate),
        .alu_rd1(fp_alu_rd1), .alu_rd2(fp_alu_rd2), .alu_alusrc(fp_alu_alusrc), .alu_auipc(fp_alu_auipc),
        .alu_lui(fp_alu_lui), .alu_result(fp_alu_result), .alu_zero(fp_alu_zero),
        .alu_negative(fp_alu_negative), .alu_overflow(fp_alu_overflow), .busy(fp_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic p, input logic v, input vec_t x);
        if (!p) begin
            req0_valid = v; req0_ctrl = x.ctrl; req0_sel = x.sel;
            req0_pc = x.pc; req0_imm = x.imm; req0_rd1 = x.rd1; req0_rd2 = x.rd2;
        end else begin
            req1_valid = v; req1_ctrl = x.ctrl; req1_sel = x.sel;
            req1_pc = x.pc; req1_imm = x.imm; req1_rd1 = x.rd1; req1_rd2 = x.rd2;
        end
    endtask

    // Waits (bounded) until the round-robin instance raises a ready; reports which.
    task automatic wait_grant(output logic gp);
        logic found;
        found = 1'b0;
        gp    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (req0_ready || req1_ready) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!found) chk("grant_timeout", 64'd0, 64'd1);
        gp = req1_ready;
    endtask

    // One complete single-port transaction with exact latency checks.
    task automatic run_vec(input vec_t x);
        logic gp;
        @(negedge clk);
        set_req(x.port, 1'b1, x);
        #1;
        wait_grant(gp);
        chk("grant_port", 64'(gp), 64'(x.port));
        chk("grant_onehot", 64'(req0_ready & req1_ready), 64'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("exec_busy", 64'(busy), 64'd1);
        chk("exec_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("exec_alu_ops", {alu_rd1, alu_rd2}, {x.rd1, x.rd2});
        chk("exec_alu_ctrl", 64'({alu_control, alu_lui, alu_auipc, alu_alusrc}), 64'({x.ctrl, x.sel}));
        @(negedge clk); #1;
        chk("rsp_valid", 64'({rsp1_valid, rsp0_valid}), x.port ? 64'd2 : 64'd1);
        chk("rsp_result", 64'(x.port ? rsp1_result : rsp0_result), 64'(x.res));
        chk("rsp_flags", 64'(x.port ? rsp1_flags : rsp0_flags), 64'(x.flg));
        @(negedge clk); #1;
        chk("back_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic gp;
        //        port ctrl  sel   pc          imm           rd1           rd2           res           flags
        vecs[0] = '{1'b0, 4'd0, 3'b000, 32'd0,      32'd0,        32'd5,        32'd7,        32'd12,       3'b000};
        vecs[1] = '{1'b1, 4'd1, 3'b000, 32'd0,      32'd0,        32'd9,        32'd4,        32'd5,        3'b000};
        vecs[2] = '{1'b0, 4'd1, 3'b000, 32'd0,      32'd0,        32'd3,        32'd3,        32'd0,        3'b100};
        vecs[3] = '{1'b1, 4'd0, 3'b000, 32'd0,      32'd0,        32'h7fffffff, 32'd1,        32'h80000000, 3'b011};
        vecs[4] = '{1'b0, 4'd0, 3'b001, 32'd0,      32'hfffffffc, 32'd100,      32'd55,       32'd96,       3'b000};
        vecs[5] = '{1'b1, 4'd0, 3'b011, 32'h1000,   32'h20,       32'd77,       32'd88,       32'h1020,     3'b000};
        vecs[6] = '{1'b0, 4'd0, 3'b101, 32'h40,     32'h12345000, 32'd1,        32'd2,        32'h12345000, 3'b000};
        vecs[7] = '{1'b1, 4'd4, 3'b000, 32'd0,      32'd0,        32'hff00ff00, 32'hffffffff, 32'h00ff00ff, 3'b000};
        vecs[8] = '{1'b0, 4'd2, 3'b000, 32'd0,      32'd0,        32'hf0,       32'h0f,       32'd0,        3'b100};

        // Reset state, with both requesters already valid.
        set_req(1'b0, 1'b1, vecs[0]);
        set_req(1'b1, 1'b1, vecs[1]);
        @(negedge clk); #1;
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("rst_alu", {alu_rd1, alu_rd2}, 64'd0);
        chk("rst_alu_ctrl", 64'({alu_control, alu_lui, alu_auipc, alu_alusrc}), 64'd0);
        chk("rst_result", 64'(rsp0_result), 64'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        // Table of single-port operations.
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Both ports valid continuously: RR alternates 0,1,0,1; fixed priority starves port 1.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        set_req(1'b0, 1'b1, vecs[0]);
        set_req(1'b1, 1'b1, vecs[1]);
        for (int i = 0; i < 4; i++) begin
            #1;
            wait_grant(gp);
            chk("rr_grant", 64'(gp), 64'(i % 2));
            chk("fp_grant", 64'({fp_req0_ready, fp_req1_ready}), 64'd2);
            @(negedge clk);
            @(negedge clk); #1;
            chk("rr_rsp_valid", 64'({rsp1_valid, rsp0_valid}), (i % 2 == 1) ? 64'd2 : 64'd1);
            chk("rr_rsp_result", 64'((i % 2 == 1) ? rsp1_result : rsp0_result), (i % 2 == 1) ? 64'd5 : 64'd12);
            chk("fp_rsp", {31'd0, fp_rsp1_valid, fp_rsp0_valid, fp_rsp0_result}, {31'd0, 2'b01, 32'd12});
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Response backpressure: held stable for four cycles.
        rsp0_ready = 1'b0;
        @(negedge clk);
        set_req(1'b0, 1'b1, vecs[2]);
        #1;
        wait_grant(gp);
        chk("bp_grant", 64'(gp), 64'd0);
        @(negedge clk); req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("bp_hold", {28'd0, rsp0_valid, rsp0_flags, rsp0_result}, {28'd0, 1'b1, 3'b100, 32'd0});
        end
        @(negedge clk); rsp0_ready = 1'b1; #1;
        chk("bp_release_valid", 64'(rsp0_valid), 64'd1);
        @(negedge clk); #1;
        chk("bp_idle", 64'({busy, rsp0_valid}), 64'd0);

        // Flush during EXEC: no response, idle next cycle.
        @(negedge clk);
        set_req(1'b0, 1'b1, vecs[0]);
        #1;
        wait_grant(gp);
        @(negedge clk); req0_valid = 1'b0; flush = 1'b1; #1;
        chk("fl_exec_busy", 64'(busy), 64'd1);
        @(negedge clk); flush = 1'b0; #1;
        chk("fl_exec_idle", 64'({busy, rsp0_valid, rsp1_valid}), 64'd0);
        // Flush in IDLE blocks the grant.
        req0_valid = 1'b1; flush = 1'b1; #1;
        chk("fl_idle_ready", 64'({req0_ready, req1_ready}), 64'd0);
        @(negedge clk); #1;
        chk("fl_idle_nogrant", 64'(busy), 64'd0);
        flush = 1'b0; req0_valid = 1'b0;
        run_vec(vecs[0]);

        // Flush in RESP together with rsp_ready: treated as flush.
        @(negedge clk);
        set_req(1'b1, 1'b1, vecs[1]);
        #1;
        wait_grant(gp);
        chk("fl_resp_grant", 64'(gp), 64'd1);
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("fl_resp_visible", 64'(rsp1_valid), 64'd1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        chk("fl_resp_idle", 64'({busy, rsp1_valid}), 64'd0);
        run_vec(vecs[2]);

        // Reset while waiting in RESP, then first grant goes to port 0.
        rsp1_ready = 1'b0;
        @(negedge clk);
        set_req(1'b1, 1'b1, vecs[3]);
        #1;
        wait_grant(gp);
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("rr_pre_rst_valid", 64'(rsp1_valid), 64'd1);
        set_req(1'b0, 1'b1, vecs[0]);
        set_req(1'b1, 1'b1, vecs[1]);
        rst = 1'b1; #1;
        chk("rst_resp_outs", 64'({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 64'd0);
        chk("rst_resp_regs", {rsp1_result, alu_rd1}, 64'd0);
        @(negedge clk); rst = 1'b0; rsp1_ready = 1'b1; #1;
        wait_grant(gp);
        chk("post_rst_grant", 64'(gp), 64'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
